// File: rtl/collision_pkg.sv
// collision_pkg: shared constants and helpers for the per-frame collision detector.
package collision_pkg;

    // Object slots on the drawing bus
    localparam int unsigned OBJ_GHOST     = 0;
    localparam int unsigned OBJ_PLAYER    = 1;
    localparam int unsigned OBJ_BULLET    = 2;
    localparam int unsigned OBJ_BORDER    = 3;
    localparam int unsigned N_OBJ_DEFAULT = 4;

    // Screen coordinate widths actually compared; upper pixel bits are ignored
    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    // Width of the colliding-frame counter
    localparam int unsigned FRAME_CNT_W = 16;

    // Saturating increment for the frame counter
    function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
        return (&v) ? v : v + FRAME_CNT_W'(1);
    endfunction

endpackage

// File: rtl/collision_holdoff.sv
// collision_holdoff: per-object hit accumulator, frame holdoff counter and pulse register.
module collision_holdoff #(
    parameter int unsigned HOLDOFF_FRAMES = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic sof,
    input  logic hit,
    output logic pulse
);

    localparam int unsigned HC_W = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);

    logic            acc_q,   acc_d;
    logic            pulse_q, pulse_d;
    logic [HC_W-1:0] hold_q,  hold_d;

    // Accumulate during the frame; at sof evaluate, reload with pixel (0,0) and step holdoff
    always_comb begin
        acc_d   = acc_q | hit;
        pulse_d = 1'b0;
        hold_d  = hold_q;
        if (sof) begin
            acc_d   = hit;
            pulse_d = acc_q && (hold_q == '0);
            if (pulse_d) begin
                hold_d = HC_W'(HOLDOFF_FRAMES);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HC_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            acc_q   <= 1'b0;
            pulse_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            pulse_q <= pulse_d;
            hold_q  <= hold_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/collision_detector.sv
// collision_detector: flags overlapping Draw requests per frame and pulses per object at frame start.
// Optional COLLISION_COORD_EN adds first_x/first_y: the first overlapping pixel of the pulsed frame.
module collision_detector
    import collision_pkg::*;
#(
    parameter int unsigned N_OBJ          = N_OBJ_DEFAULT,
    parameter int unsigned HOLDOFF_FRAMES = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [31:0]            pxl_x,
    input  logic [31:0]            pxl_y,
    input  logic [N_OBJ-1:0]       draw,
    output logic [N_OBJ-1:0]       collision,
    output logic                   any_collision,
`ifdef COLLISION_COORD_EN
    output logic [X_W-1:0]         first_x,
    output logic [Y_W-1:0]         first_y,
`endif
    output logic [FRAME_CNT_W-1:0] frame_hits
);

    logic [X_W-1:0]         x_lo;
    logic [Y_W-1:0]         y_lo;
    logic                   unused_upper;
    logic                   origin_c;
    logic                   sof_c;
    logic [N_OBJ-1:0]       hit_c;
    logic                   prev_origin_q, prev_origin_d;
    logic [FRAME_CNT_W-1:0] frame_hits_q,  frame_hits_d;

    assign x_lo         = pxl_x[X_W-1:0];
    assign y_lo         = pxl_y[Y_W-1:0];
    assign unused_upper = ^{pxl_x[31:X_W], pxl_y[31:Y_W]};
    assign origin_c     = (x_lo == '0) && (y_lo == '0);
    assign sof_c        = origin_c && !prev_origin_q;

    // An object hits when it draws and at least one other object draws the same pixel
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(N_OBJ); i++) begin
            hit_c[i] = draw[i] && ((draw & ~(N_OBJ'(1) << i)) != '0);
        end
    end

    // Sof history and colliding-frame counter
    always_comb begin
        prev_origin_d = origin_c;
        frame_hits_d  = frame_hits_q;
        if (collision != '0) begin
            frame_hits_d = sat_inc(frame_hits_q);
        end
    end

    // Top-level registers; reset history as "previous pixel was (0,0)"
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            prev_origin_q <= 1'b1;
            frame_hits_q  <= '0;
        end else begin
            prev_origin_q <= prev_origin_d;
            frame_hits_q  <= frame_hits_d;
        end
    end

    for (genvar g = 0; g < int'(N_OBJ); g++) begin : g_obj
        collision_holdoff #(
            .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
        ) u_holdoff (
            .clk   (clk),
            .resetN(resetN),
            .sof   (sof_c),
            .hit   (hit_c[g]),
            .pulse (collision[g])
        );
    end

    assign any_collision = |collision;
    assign frame_hits    = frame_hits_q;

`ifdef COLLISION_COORD_EN
    logic           cand_valid_q, cand_valid_d;
    logic [X_W-1:0] cand_x_q, cand_x_d, snap_x_q, snap_x_d, first_x_q, first_x_d;
    logic [Y_W-1:0] cand_y_q, cand_y_d, snap_y_q, snap_y_d, first_y_q, first_y_d;

    // Track first overlap of the running frame, snapshot it at sof, publish it with a pulse
    always_comb begin
        cand_valid_d = cand_valid_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        first_x_d    = first_x_q;
        first_y_d    = first_y_q;
        if (sof_c) begin
            snap_x_d     = cand_x_q;
            snap_y_d     = cand_y_q;
            cand_valid_d = (hit_c != '0);
            cand_x_d     = '0;
            cand_y_d     = '0;
        end else if ((hit_c != '0) && !cand_valid_q) begin
            cand_valid_d = 1'b1;
            cand_x_d     = x_lo;
            cand_y_d     = y_lo;
        end
        if (collision != '0) begin
            first_x_d = snap_x_q;
            first_y_d = snap_y_q;
        end
    end

    // Coordinate capture registers
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            cand_valid_q <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            first_x_q    <= '0;
            first_y_q    <= '0;
        end else begin
            cand_valid_q <= cand_valid_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            first_x_q    <= first_x_d;
            first_y_q    <= first_y_d;
        end
    end

    assign first_x = first_x_q;
    assign first_y = first_y_q;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: table vectors, directed corner sequences and random frames vs a frame-level model.
module tb_collision_detector;

    localparam int N = 4;
    localparam int H = 8;

    logic          clk = 1'b0;
    logic          resetN;
    logic [31:0]   pxl_x;
    logic [31:0]   pxl_y;
    logic [N-1:0]  draw;
    logic [N-1:0]  collision;
    logic          any_collision;
    logic [15:0]   frame_hits;
`ifdef COLLISION_COORD_EN
    logic [9:0]    first_x;
    logic [8:0]    first_y;
`endif

    collision_detector #(.N_OBJ(N), .HOLDOFF_FRAMES(H)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .pxl_x        (pxl_x),
        .pxl_y        (pxl_y),
        .draw         (draw),
        .collision    (collision),
        .any_collision(any_collision),
`ifdef COLLISION_COORD_EN
        .first_x      (first_x),
        .first_y      (first_y),
`endif
        .frame_hits   (frame_hits)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: frame-level view of the rules
    logic         m_prev_origin;
    logic [N-1:0] m_frame;
    logic [N-1:0] m_coll;
    int           m_hold [N];
    int           m_fh;
    logic         m_cand_valid;
    int           m_cand_x, m_cand_y, m_snap_x, m_snap_y, m_first_x, m_first_y;

    typedef struct {
        logic [31:0]  x;
        logic [31:0]  y;
        logic [N-1:0] d;
        logic [N-1:0] exp_coll;
        int           exp_fh;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_origin = 1'b1;
        m_frame       = '0;
        m_coll        = '0;
        m_fh          = 0;
        for (int i = 0; i < N; i++) m_hold[i] = 0;
        m_cand_valid  = 1'b0;
        m_cand_x = 0; m_cand_y = 0; m_snap_x = 0; m_snap_y = 0; m_first_x = 0; m_first_y = 0;
    endtask

    task automatic model_advance(input logic [31:0] x, input logic [31:0] y, input logic [N-1:0] d);
        logic         origin;
        logic         sof;
        logic [N-1:0] hit;
        logic [N-1:0] nc;
        origin = (x[9:0] == 10'd0) && (y[8:0] == 9'd0);
        sof    = origin && !m_prev_origin;
        hit    = ($countones(d) >= 2) ? d : '0;
        nc     = '0;
        if (m_coll != '0) begin
            m_first_x = m_snap_x;
            m_first_y = m_snap_y;
            if (m_fh < 65535) m_fh++;
        end
        if (sof) begin
            for (int i = 0; i < N; i++) begin
                if (m_frame[i] && m_hold[i] == 0) begin
                    nc[i]     = 1'b1;
                    m_hold[i] = H;
                end else if (m_hold[i] > 0) begin
                    m_hold[i]--;
                end
            end
            m_snap_x     = m_cand_x;
            m_snap_y     = m_cand_y;
            m_cand_valid = (hit != '0);
            m_cand_x     = 0;
            m_cand_y     = 0;
            m_frame      = hit;
        end else begin
            m_frame = m_frame | hit;
            if (hit != '0 && !m_cand_valid) begin
                m_cand_valid = 1'b1;
                m_cand_x     = int'(x[9:0]);
                m_cand_y     = int'(y[8:0]);
            end
        end
        m_coll        = nc;
        m_prev_origin = origin;
    endtask

    // One pixel: drive, clock, compare every output against the model
    task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [N-1:0] d);
        pxl_x = x;
        pxl_y = y;
        draw  = d;
        model_advance(x, y, d);
        @(posedge clk);
        #1;
        check("collision", 32'(collision), 32'(m_coll));
        check("any_collision", 32'(any_collision), 32'(m_coll != '0));
        check("frame_hits", 32'(frame_hits), 32'(m_fh));
`ifdef COLLISION_COORD_EN
        check("first_x", 32'(first_x), 32'(m_first_x));
        check("first_y", 32'(first_y), 32'(m_first_y));
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        resetN = 1'b1;
        model_reset();
        #2;
        check("rst_collision", 32'(collision), 32'(0));
        check("rst_any", 32'(any_collision), 32'(0));
        check("rst_frame_hits", 32'(frame_hits), 32'(0));
        @(posedge clk);
        #1;
        resetN = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [N-1:0] rd;
        resetN = 1'b1;
        pxl_x  = '0;
        pxl_y  = '0;
        draw   = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Table: single overlap, last-pixel overlap, origin overlap under holdoff
        tbl[0]  = '{32'd0,   32'd0,   4'b0000, 4'b0000, 0};
        tbl[1]  = '{32'd100, 32'd50,  4'b0011, 4'b0000, 0};
        tbl[2]  = '{32'd101, 32'd50,  4'b0001, 4'b0000, 0};
        tbl[3]  = '{32'd639, 32'd479, 4'b0000, 4'b0000, 0};
        tbl[4]  = '{32'd0,   32'd0,   4'b0000, 4'b0011, 0};
        tbl[5]  = '{32'd1,   32'd0,   4'b0000, 4'b0000, 1};
        tbl[6]  = '{32'd639, 32'd479, 4'b1100, 4'b0000, 1};
        tbl[7]  = '{32'd0,   32'd0,   4'b0000, 4'b1100, 1};
        tbl[8]  = '{32'd1,   32'd0,   4'b0000, 4'b0000, 2};
        tbl[9]  = '{32'd0,   32'd0,   4'b0011, 4'b0000, 2};
        tbl[10] = '{32'd1,   32'd0,   4'b0000, 4'b0000, 2};
        tbl[11] = '{32'd0,   32'd0,   4'b0000, 4'b0000, 2};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].x, tbl[k].y, tbl[k].d);
            check($sformatf("tbl%0d_coll", k), 32'(collision), 32'(tbl[k].exp_coll));
            check($sformatf("tbl%0d_fh", k), 32'(frame_hits), 32'(tbl[k].exp_fh));
        end

        // Overlap every frame: pulses only at boundaries 1, 10, 19
        do_reset();
        step(32'd7, 32'd7, 4'b0011);
        for (int b = 1; b <= 20; b++) begin
            step(32'd0, 32'd0, 4'b0000);
            check($sformatf("holdoff_b%0d", b), 32'(collision[0]), 32'(b == 1 || b == 10 || b == 19));
            step(32'd50, 32'd50, 4'b0011);
        end

        // Overlap only at (0,0): pulse one frame later
        do_reset();
        step(32'd5, 32'd5, 4'b0000);
        step(32'd0, 32'd0, 4'b0011);
        check("origin_not_now", 32'(collision), 32'(0));
        step(32'd1, 32'd0, 4'b0000);
        step(32'd0, 32'd0, 4'b0000);
        check("origin_next_frame", 32'(collision), 32'(4'b0011));

        // Overlap only at the last pixel
        do_reset();
        step(32'd5, 32'd5, 4'b0000);
        step(32'd639, 32'd479, 4'b0101);
        step(32'd0, 32'd0, 4'b0000);
        check("last_pixel", 32'(collision), 32'(4'b0101));

        // Coordinates held at (0,0) for five cycles: a single pulse
        do_reset();
        step(32'd3, 32'd3, 4'b0011);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(32'd0, 32'd0, 4'b0000);
            if (collision != '0) pulses++;
        end
        step(32'd1, 32'd1, 4'b0000);
        if (collision != '0) pulses++;
        check("held_origin_pulses", 32'(pulses), 32'(1));

        // Reset mid-frame discards the partial frame
        do_reset();
        step(32'd5, 32'd5, 4'b0000);
        step(32'd200, 32'd300, 4'b0011);
        pxl_x = 32'd400;
        pxl_y = 32'd0;
        draw  = 4'b0000;
        do_reset();
        step(32'd639, 32'd479, 4'b0000);
        step(32'd0, 32'd0, 4'b0000);
        check("midreset_coll", 32'(collision), 32'(0));
        check("midreset_fh", 32'(frame_hits), 32'(0));

`ifdef COLLISION_COORD_EN
        // First overlapping pixel is reported for the pulsed frame
        do_reset();
        step(32'd5, 32'd5, 4'b0000);
        step(32'd30, 32'd40, 4'b0011);
        step(32'd500, 32'd400, 4'b0110);
        step(32'd0, 32'd0, 4'b0000);
        check("coord_coll", 32'(collision), 32'(4'b0111));
        step(32'd1, 32'd0, 4'b0000);
        check("coord_x", 32'(first_x), 32'(30));
        check("coord_y", 32'(first_y), 32'(40));
`endif

        // Random frames with ignored upper coordinate bits and occasional resets
        do_reset();
        for (int f = 0; f < 300; f++) begin
            int len;
            len = int'($urandom_range(1, 10));
            for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
                rd = N'($urandom) & N'($urandom);
                step({22'($urandom), 10'd0}, {23'($urandom), 9'd0}, rd);
            end
            for (int p = 0; p < len; p++) begin
                rd = N'($urandom) & N'($urandom);
                step({22'($urandom), 10'($urandom_range(1, 639))},
                     {23'($urandom), 9'($urandom_range(0, 479))}, rd);
            end
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
# collision_detector

Per-frame collision detector for the arcade template. It sits directly upstream of the ghost unit and its siblings. Each pixel clock it watches the `Draw` request of every on-screen object and flags any object whose request overlaps another object's. At each frame start it issues one-cycle `collision` pulses, one per object, rate-limited by a per-object frame holdoff. Bit `OBJ_GHOST` of the pulse vector drives the ghost unit's `collision` input.

## Interface
- `N_OBJ`, default 4: number of drawing objects (minimum 2).
- `HOLDOFF_FRAMES`, default 8: frames suppressed after a pulse for that object; 0 disables holdoff.
- `clk` in 1: pixel clock; one pixel per cycle.
- `resetN` in 1: reset, asynchronous and active-high. The port name is kept for consistency with sibling units; asserted = 1.
- `pxl_x` in 32: current pixel column.
- `pxl_y` in 32: current pixel row.
- `draw` in N_OBJ: per-object `Draw` request for the current pixel.
- `collision` out N_OBJ: one-cycle pulse per object at frame start.
- `any_collision` out 1: OR of `collision`, same cycle.
- `frame_hits` out 16: saturating count of frames in which at least one pulse fired.

## Operation
- Frame start (sof) is pixel (0,0) seen in the current cycle while the previous cycle was not (0,0). The comparison uses bits [9:0] of `pxl_x` and bits [8:0] of `pxl_y`; upper bits are ignored.
- Per-pixel hit for object i: `draw[i]` AND (any `draw[j]`, j≠i). The term is combinational and not registered.
- Accumulator `acc[i]` is set by hit[i] on every non-sof cycle.
- On a sof cycle:
  - The pending value for object i is `acc[i]`, or the current cycle's hit[i] on a non-sof cycle.
  - `collision[i]` is registered as pending AND (`hold_cnt[i]` == 0).
  - `acc[i]` is reloaded with the current pixel's hit[i], because pixel (0,0) belongs to the new frame.
- Holdoff, per object:
  - When `collision[i]` is issued, `hold_cnt[i]` loads `HOLDOFF_FRAMES`.
  - Otherwise `hold_cnt[i]` decrements on each sof while nonzero.
  - A hit in a frame that is evaluated while `hold_cnt[i]` is nonzero is discarded, not deferred.
- `frame_hits` increments on the cycle after sof when any pulse fires. It saturates at 16'hFFFF.
- No state machine beyond the accumulate/evaluate alternation; all objects evaluate in parallel.

## Timing
- Reset values:
  - `collision` = 0, `any_collision` = 0, `frame_hits` = 0.
  - `acc` = 0, `hold_cnt` = 0.
  - sof history = "previous pixel was (0,0)", so the first (0,0) after reset does not produce a pulse.
- Latency: `collision` is high exactly the cycle after the sof cycle, for exactly one cycle.
- The last pixel of a frame, evaluated in the cycle just before sof, is included in that frame's evaluation.
- If pixel coordinates hold at (0,0) for several cycles, only the first of those cycles is sof.
- Simultaneous pulse and holdoff reload for the same object: the reload wins over the decrement.
- `HOLDOFF_FRAMES` = 0: every colliding frame pulses.
- Reset asserted mid-frame clears accumulated hits; the partial frame never pulses.

## Configuration
- `COLLISION_COORD_EN` defined: adds two outputs.
  - `first_x` out 10 and `first_y` out 9: coordinates of the first overlapping pixel (any object) in the frame.
  - Both are latched into output registers in the same cycle as `collision`.
  - Both hold their value until the next pulse; reset value 0.
  - A frame with no issued pulse leaves them unchanged.
- `COLLISION_COORD_EN` undefined: the ports and their capture logic are absent; all other behaviour is identical.

## Structure
- `collision_pkg` holds:
  - object index constants: `OBJ_GHOST` = 0, `OBJ_PLAYER` = 1, `OBJ_BULLET` = 2, `OBJ_BORDER` = 3;
  - `N_OBJ_DEFAULT`;
  - screen coordinate widths: `X_W` = 10, `Y_W` = 9;
  - the frame-counter width (16).
- One sub-module, `collision_holdoff`, instantiated `N_OBJ` times. It contains the per-object accumulator, holdoff counter and pulse register. Ports: `clk`, `resetN`, `sof`, `hit`, `pulse`.

## Test plan
- Ghost and player `draw` both high at pixel (100,50), no other overlap → next sof: `collision` = 4'b0011 for one cycle, `any_collision` = 1, `frame_hits` = 1.
- Overlap in every frame with `HOLDOFF_FRAMES` = 8 → the ghost pulses at frame boundaries 1, 10, 19; frames 2–9 are silent.
- Overlap only at the final pixel (639,479) → pulse fires at the following sof. Overlap only at (0,0) → pulse fires one frame later, not immediately.
- Coordinates held at (0,0) for 5 cycles, with an overlap in the prior frame → exactly one pulse.
- Overlap at (200,300), then reset asserted at (400,0) of the same frame → no pulse at the next sof, and all outputs read 0.
- `COLLISION_COORD_EN` defined, overlaps at (30,40) then (500,400) in one frame → `first_x` = 30, `first_y` = 40 with the pulse.
